reduce_out_router: RTL

- Downstream stage of the per-rank reduction tile; consumes the completed reduction flits (Outpacket/valid_out/done) emitted by the reduce unit.
- Computes the next-hop direction on the 8x8x8 torus (dimension-order X, then Y, then Z, shortest way round).
- Buffers flits in a small FIFO and presents them to the router injection port with a valid/ready handshake.
- The reduce unit cannot be back-pressured, so this block absorbs bursts and flags overflow.

---
 rtl/reduce_pkg.sv | 50 +++++
 rtl/dor_route.sv | 38 +++
 rtl/reduce_out_router.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
// reduce_pkg : shared flit layout, direction codes and torus hop decision
// Rev 1.0
// ============================================================================
package reduce_pkg;

  localparam int FLIT_WIDTH    = 82;
  localparam int DST_X_POS     = 72;
  localparam int DST_Y_POS     = 75;
  localparam int DST_Z_POS     = 78;
  localparam int COORD_WIDTH   = 3;
  localparam int VALID_BIT_POS = 81;

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_XP    = 3'd1;
  localparam logic [2:0] DIR_XN    = 3'd2;
  localparam logic [2:0] DIR_YP    = 3'd3;
  localparam logic [2:0] DIR_YN    = 3'd4;
  localparam logic [2:0] DIR_ZP    = 3'd5;
  localparam logic [2:0] DIR_ZN    = 3'd6;

  // Half the ring: an offset of exactly half goes the plus way.
  localparam logic [COORD_WIDTH-1:0] DIM_HALF = COORD_WIDTH'(1 << (COORD_WIDTH - 1));

  typedef struct packed {
    logic       hit;
    logic [2:0] dir;
  } dim_route_t;

  typedef struct packed {
    logic                  done;
    logic [2:0]            dir;
    logic [FLIT_WIDTH-1:0] flit;
  } fifo_entry_t;

  function automatic dim_route_t dim_route(input logic [COORD_WIDTH-1:0] dst,
                                           input logic [COORD_WIDTH-1:0] rank,
                                           input logic [2:0]             dir_p,
                                           input logic [2:0]             dir_n);
    dim_route_t                 r;
    logic [COORD_WIDTH-1:0]     d;
    d     = dst - rank;
    r.hit = (d != '0);
    r.dir = (d <= DIM_HALF) ? dir_p : dir_n;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dor_route.sv
`default_nettype none
// ============================================================================
// dor_route : combinational dimension-order (X,Y,Z) next-hop on the torus
// Rev 1.0
// ============================================================================
module dor_route
  import reduce_pkg::*;
(
  input  logic [FLIT_WIDTH-1:0]  flit_i,
  input  logic [COORD_WIDTH-1:0] rank_x_i,
  input  logic [COORD_WIDTH-1:0] rank_y_i,
  input  logic [COORD_WIDTH-1:0] rank_z_i,
  output logic [2:0]             dir_o
);

  dim_route_t x_route;
  dim_route_t y_route;
  dim_route_t z_route;
  logic       unused_flit_bits;

  assign unused_flit_bits = ^{flit_i[VALID_BIT_POS], flit_i[DST_X_POS-1:0]};

  always_comb begin
    x_route = dim_route(flit_i[DST_X_POS +: COORD_WIDTH], rank_x_i, DIR_XP, DIR_XN);
    y_route = dim_route(flit_i[DST_Y_POS +: COORD_WIDTH], rank_y_i, DIR_YP, DIR_YN);
    z_route = dim_route(flit_i[DST_Z_POS +: COORD_WIDTH], rank_z_i, DIR_ZP, DIR_ZN);
    dir_o   = DIR_LOCAL;
    if (x_route.hit) begin
      dir_o = x_route.dir;
    end else if (y_route.hit) begin
      dir_o = y_route.dir;
    end else if (z_route.hit) begin
      dir_o = z_route.dir;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reduce_out_router.sv
`default_nettype none
// ============================================================================
// reduce_out_router : routes reduction flits and buffers them in a FWFT FIFO
// Rev 1.0
// ============================================================================
module reduce_out_router
  import reduce_pkg::*;
#(
  parameter logic [COORD_WIDTH-1:0] RANK_X          = '0,
  parameter logic [COORD_WIDTH-1:0] RANK_Y          = '0,
  parameter logic [COORD_WIDTH-1:0] RANK_Z          = '0,
  parameter int                     FIFO_DEPTH      = 8,
  parameter int                     FIFO_ADDR_WIDTH = 3,
  parameter int                     DONE_CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_WIDTH-1:0]      in_flit,
  input  logic                       in_valid,
  input  logic                       in_done,
  output logic [FLIT_WIDTH-1:0]      out_flit,
  output logic [2:0]                 out_dir,
  output logic                       out_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
  output logic                       overflow,
  output logic [DONE_CNT_WIDTH-1:0]  done_count
);

  localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

  logic                      s1_valid_q;
  logic [FLIT_WIDTH-1:0]     s1_flit_q;
  logic                      s1_done_q;
  logic [2:0]                s1_dir;

  fifo_entry_t               mem_q [FIFO_DEPTH];
  fifo_entry_t               head;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      overflow_q;
  logic [DONE_CNT_WIDTH-1:0] done_count_q;

  logic full, push, pop, push_ok, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_flit_q  <= '0;
      s1_done_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid & in_flit[VALID_BIT_POS];
      s1_flit_q  <= in_flit;
      s1_done_q  <= in_done;
    end
  end

  dor_route u_dor_route (
    .flit_i   (s1_flit_q),
    .rank_x_i (RANK_X),
    .rank_y_i (RANK_Y),
    .rank_z_i (RANK_Z),
    .dir_o    (s1_dir)
  );

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = s1_valid_q;
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= '{done: s1_done_q, dir: s1_dir, flit: s1_flit_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (pop && head.done) begin
        done_count_q <= done_count_q + DONE_CNT_WIDTH'(1);
      end
    end
  end

  // Head fields are masked while empty so stale storage never reaches the port.
  assign out_flit   = out_valid ? head.flit : '0;
  assign out_dir    = out_valid ? head.dir  : DIR_LOCAL;
  assign out_done   = out_valid & head.done;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign done_count = done_count_q;

endmodule
`default_nettype wire
